frame_packetizer: RTL and testbench

- Wraps the stream of packed pixel bytes from the packing stage into self-delimiting frames for the host link.
- Frame format: two sync bytes, a sequence number, exactly `payload_len_p` payload bytes, then an additive checksum.
- Sits directly downstream of the pixel packer and upstream of the serial transmitter.
- Uses ready/valid on both sides. Payload bytes pass through combinationally; header and trailer bytes are generated internally.

---
 rtl/frame_packetizer.sv | 135 +++++++++++++
 tb/tb_frame_packetizer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_packetizer.sv
// frame_packetizer
// Wraps a stream of payload bytes into frames of the form
//   sync0, sync1, seq, payload[payload_len_p], checksum
// Header and trailer bytes come from internal state. Payload bytes pass
// through combinationally, so in PAYLOAD the block adds no latency and
// no storage.
//
// Handshake: a byte moves on a side only in a cycle where that side's
// valid and ready are both high.
//   - Input fire  = valid_i & ready_o
//   - Output fire = valid_o & ready_i
// A producer that raises valid must hold its data stable until the fire.
// valid_o never depends on ready_i. In PAYLOAD, valid_o mirrors valid_i
// and ready_o mirrors ready_i.
module frame_packetizer #(
  parameter int unsigned       width_p       = 8,
  parameter int unsigned       payload_len_p = 160,
  parameter logic [width_p-1:0] sync0_p      = 8'hA5,
  parameter logic [width_p-1:0] sync1_p      = 8'h5A
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               last_o,
  output logic [2:0]         state_o
);

  // A frame of one payload byte still needs a 1-bit counter.
  localparam int cnt_w = (payload_len_p > 1) ? $clog2(payload_len_p) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(payload_len_p - 1);

  localparam logic [2:0] st_idle    = 3'd0;
  localparam logic [2:0] st_sync0   = 3'd1;
  localparam logic [2:0] st_sync1   = 3'd2;
  localparam logic [2:0] st_seq     = 3'd3;
  localparam logic [2:0] st_payload = 3'd4;
  localparam logic [2:0] st_csum    = 3'd5;

  logic [2:0]         state_r;
  logic [width_p-1:0] seq_r;
  logic [width_p-1:0] csum_r;
  logic [cnt_w-1:0]   count_r;
  logic               in_fire;
  logic               out_fire;

  assign state_o  = state_r;
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  // Output decode. IDLE, which is also the reset state, drives all outputs low.
  always_comb begin
    valid_o = 1'b0;
    ready_o = 1'b0;
    data_o  = '0;
    last_o  = 1'b0;
    case (state_r)
      st_sync0: begin
        valid_o = 1'b1;
        data_o  = sync0_p;
      end
      st_sync1: begin
        valid_o = 1'b1;
        data_o  = sync1_p;
      end
      st_seq: begin
        valid_o = 1'b1;
        data_o  = seq_r;
      end
      st_payload: begin
        valid_o = valid_i;
        ready_o = ready_i;
        data_o  = data_i;
      end
      st_csum: begin
        valid_o = 1'b1;
        data_o  = csum_r;
        last_o  = 1'b1;
      end
      default: ;
    endcase
  end

  // Frame sequencing, sequence number, checksum and payload counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= st_idle;
      seq_r   <= '0;
      csum_r  <= '0;
      count_r <= '0;
    end else begin
      case (state_r)
        st_idle: begin
          // No frame is started until payload is waiting; nothing is consumed here.
          if (valid_i) state_r <= st_sync0;
        end
        st_sync0: begin
          if (out_fire) state_r <= st_sync1;
        end
        st_sync1: begin
          if (out_fire) state_r <= st_seq;
        end
        st_seq: begin
          if (out_fire) begin
            csum_r  <= seq_r;
            state_r <= st_payload;
          end
        end
        st_payload: begin
          if (in_fire) begin
            csum_r <= csum_r + data_i;
            if (count_r == cnt_last) begin
              count_r <= '0;
              state_r <= st_csum;
            end else begin
              count_r <= count_r + cnt_w'(1);
            end
          end
        end
        st_csum: begin
          if (out_fire) begin
            seq_r   <= seq_r + width_p'(1);
            state_r <= st_idle;
          end
        end
        default: state_r <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_packetizer.sv
// Directed testbench for frame_packetizer. A 4-byte-payload instance
// carries most of the scenarios; a second instance at the default length of
// 160 repeats the single-frame case. Inputs are driven 1 ns after the rising
// edge, and outputs are sampled on the falling edge.
module tb_frame_packetizer;

  localparam logic [2:0] s_idle    = 3'd0;
  localparam logic [2:0] s_sync1   = 3'd2;
  localparam logic [2:0] s_payload = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT, payload_len_p = 4 ----------------
  logic [7:0] data_i, data_o;
  logic       valid_i, ready_o, valid_o, ready_i, last_o;
  logic [2:0] state_o;

  frame_packetizer #(.width_p(8), .payload_len_p(4)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .last_o(last_o), .state_o(state_o)
  );

  // ---------------- DUT, default payload_len_p = 160 ----------------
  logic [7:0] l_data_i, l_data_o;
  logic       l_valid_i, l_ready_o, l_valid_o, l_ready_i, l_last_o;
  logic [2:0] l_state_o;

  frame_packetizer dut_long (
    .clk_i(clk), .reset_n_i(rst_n),
    .data_i(l_data_i), .valid_i(l_valid_i), .ready_o(l_ready_o),
    .data_o(l_data_o), .valid_o(l_valid_o), .ready_i(l_ready_i),
    .last_o(l_last_o), .state_o(l_state_o)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Entered at posedge+1 with the DUT in IDLE. Drives one frame while checking
  // every output byte against exp_q.
  //   stall_k/stall_n : hold ready_i low for stall_n cycles while on byte stall_k.
  //   gap_k/gap_n     : drop valid_i for gap_n cycles after byte gap_k fires.
  //   abort_k         : pulse reset between edges on reaching byte abort_k.
  // Negative values disable each option. Returns at posedge+1.
  task automatic run_frame(input logic [7:0] p0, p1, p2, p3,
                           input logic [7:0] seq, input logic [7:0] csum,
                           input int stall_k, input int stall_n,
                           input int gap_k, input int gap_n, input int abort_k);
    logic [7:0] pay [4];
    logic [7:0] e;
    pay[0] = p0; pay[1] = p1; pay[2] = p2; pay[3] = p3;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(seq);
    for (int i = 0; i < 4; i++) exp_q.push_back(pay[i]);
    exp_q.push_back(csum);

    // Idle bubble: upstream has data waiting but nothing is emitted yet.
    valid_i = 1'b1;
    ready_i = 1'b1;
    data_i  = p0;
    @(negedge clk);
    chk("idle_valid_o", valid_o, 1'b0);
    chk("idle_ready_o", ready_o, 1'b0);
    chk("idle_state", state_o, s_idle);
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) begin
      if (k >= 3 && k <= 6) data_i = pay[k-3];
      if (k == abort_k) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid_o", valid_o, 1'b0);
        chk("rst_ready_o", ready_o, 1'b0);
        chk("rst_last_o", last_o, 1'b0);
        chk("rst_data_o", data_o, 8'h00);
        chk("rst_state", state_o, s_idle);
        valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        return;
      end
      e = exp_q[0];
      if (k == stall_k) begin
        for (int s = 0; s < stall_n; s++) begin
          ready_i = 1'b0;
          @(negedge clk);
          chk("stall_data_o", data_o, e);
          chk("stall_valid_o", valid_o, 1'b1);
          chk("stall_ready_o", ready_o, 1'b0);
          @(posedge clk); #1;
        end
        ready_i = 1'b1;
      end
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("byte%0d_data_o", k), data_o, e);
      chk($sformatf("byte%0d_valid_o", k), valid_o, 1'b1);
      chk($sformatf("byte%0d_last_o", k), last_o, (k == 7) ? 1'b1 : 1'b0);
      chk($sformatf("byte%0d_ready_o", k), ready_o, (k >= 3 && k <= 6) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
      if (k == gap_k) begin
        valid_i = 1'b0;
        for (int g = 0; g < gap_n; g++) begin
          @(negedge clk);
          chk("gap_valid_o", valid_o, 1'b0);
          chk("gap_state", state_o, s_payload);
          @(posedge clk); #1;
        end
        valid_i = 1'b1;
      end
    end
    valid_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    data_i    = 8'h00;
    valid_i   = 1'b0;
    ready_i   = 1'b0;
    l_data_i  = 8'h00;
    l_valid_i = 1'b0;
    l_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state with upstream already offering data: nothing is consumed.
    valid_i = 1'b1;
    ready_i = 1'b1;
    #1;
    chk("reset_valid_o", valid_o, 1'b0);
    chk("reset_ready_o", ready_o, 1'b0);
    chk("reset_last_o", last_o, 1'b0);
    chk("reset_data_o", data_o, 8'h00);
    chk("reset_state", state_o, s_idle);
    @(posedge clk); #1;
    chk("reset_hold_state", state_o, s_idle);
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_valid_state", state_o, s_idle);

    // Single frame: A5 5A 00 01 02 03 04 0A.
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h0A, -1, 0, -1, 0, -1);
    // Back-to-back: seq 01, checksum 0B, exactly one idle bubble in between.
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h0B, -1, 0, -1, 0, -1);
    // Backpressure in SYNC1 for 3 cycles: 02+10+20+30+40 = A2.
    run_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h02, 8'hA2, 1, 3, -1, 0, -1);
    // Upstream gap of 5 cycles after payload byte 2: 03+01+02+03+04 = 0D.
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h03, 8'h0D, -1, 0, 4, 5, -1);
    // Async reset after two payload bytes of the seq-04 frame.
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h0E, -1, 0, -1, 0, 5);
    chk("post_reset_state", state_o, s_idle);
    // The next frame restarts with sequence 00.
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h0A, -1, 0, -1, 0, -1);
    // Sequence wrap: seq 01..FF, payload {s,0,0,0} gives checksum 2*s mod 256.
    for (int s = 1; s < 256; s++)
      run_frame(8'(s), 8'h00, 8'h00, 8'h00, 8'(s), 8'(2 * s), -1, 0, -1, 0, -1);
    // After FF the sequence is 00 again: 00 + 4*FF = FC mod 256.
    run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFC, -1, 0, -1, 0, -1);

    // Default-length instance: payload 1..160 with seq 00 gives 12880 mod 256 = 50.
    l_valid_i = 1'b1;
    l_ready_i = 1'b1;
    l_data_i  = 8'h01;
    @(negedge clk);
    chk("long_idle_valid_o", l_valid_o, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 164; k++) begin
      logic [7:0] e;
      if (k == 0)       e = 8'hA5;
      else if (k == 1)  e = 8'h5A;
      else if (k == 2)  e = 8'h00;
      else if (k < 163) e = 8'(k - 2);
      else              e = 8'h50;
      l_data_i = (k >= 3 && k < 163) ? 8'(k - 2) : 8'h00;
      @(negedge clk);
      chk($sformatf("long_byte%0d_data_o", k), l_data_o, e);
      chk($sformatf("long_byte%0d_last_o", k), l_last_o, (k == 163) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
    end
    l_valid_i = 1'b0;
    @(negedge clk);
    chk("long_end_state", l_state_o, s_idle);
    chk("long_end_valid_o", l_valid_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
